// File: rtl/masked_round_ctrl.sv
// Round sequencer for a pipelined masked datapath; each round waits for fresh PRNG randomness.
// Define CTRL_FLUSH_EN to add a post-operation register flush phase (FLUSH state, out_clear).
module masked_round_ctrl #(
    parameter int NUM_ROUNDS   = 10,
    parameter int PIPE_STAGES  = 2,
    parameter int FLUSH_CYCLES = 2,
    localparam int RW = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1
) (
    input  logic          in_clock,
    input  logic          in_reset,
    input  logic          in_start,
    input  logic          in_rand_valid,
    output logic          out_rand_ready,
    output logic          out_busy,
    output logic          out_done,
    output logic          out_load,
    output logic          out_enable,
    output logic [RW-1:0] out_round,
    output logic          out_last,
    output logic          out_clear
);

    localparam int SW = (PIPE_STAGES > 1) ? $clog2(PIPE_STAGES) : 1;
    localparam logic [SW-1:0] LAST_STAGE = SW'(PIPE_STAGES - 1);
    localparam logic [RW-1:0] LAST_ROUND = RW'(NUM_ROUNDS - 1);

    if ((NUM_ROUNDS < 1) || (PIPE_STAGES < 1) || (FLUSH_CYCLES < 1)) begin : g_param_check
        $error("masked_round_ctrl: NUM_ROUNDS, PIPE_STAGES and FLUSH_CYCLES must all be >= 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ROUND = 3'd2,
        ST_DONE  = 3'd3
`ifdef CTRL_FLUSH_EN
        ,
        ST_FLUSH = 3'd4
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] stage_q, stage_d;
    logic [RW-1:0] round_q, round_d;
    logic          advance;

`ifdef CTRL_FLUSH_EN
    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FW-1:0] LAST_FLUSH = FW'(FLUSH_CYCLES - 1);
    logic [FW-1:0] flush_q, flush_d;
`endif

    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            state_q <= ST_IDLE;
            stage_q <= '0;
            round_q <= '0;
`ifdef CTRL_FLUSH_EN
            flush_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            round_q <= round_d;
`ifdef CTRL_FLUSH_EN
            flush_q <= flush_d;
`endif
        end
    end

    // A round only starts (stage 0) when randomness is handed over; later stages free-run.
    always_comb begin
        state_d        = state_q;
        stage_d        = stage_q;
        round_d        = round_q;
        advance        = 1'b0;
        out_rand_ready = 1'b0;
        out_busy       = 1'b0;
        out_done       = 1'b0;
        out_load       = 1'b0;
        out_enable     = 1'b0;
        out_round      = '0;
        out_last       = 1'b0;
`ifdef CTRL_FLUSH_EN
        flush_d        = flush_q;
        out_clear      = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (in_start) begin
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                out_load   = 1'b1;
                out_enable = 1'b1;
                out_busy   = 1'b1;
                stage_d    = '0;
                round_d    = '0;
                state_d    = ST_ROUND;
            end

            ST_ROUND: begin
                out_busy       = 1'b1;
                out_rand_ready = (stage_q == '0);
                advance        = (stage_q != '0) || in_rand_valid;
                out_enable     = advance;
                out_round      = round_q;
                out_last       = (round_q == LAST_ROUND);
                if (advance) begin
                    if (stage_q == LAST_STAGE) begin
                        stage_d = '0;
                        if (round_q == LAST_ROUND) begin
                            state_d = ST_DONE;
                        end else begin
                            round_d = round_q + 1'b1;
                        end
                    end else begin
                        stage_d = stage_q + 1'b1;
                    end
                end
            end

            ST_DONE: begin
                out_done  = 1'b1;
                out_round = round_q;
                round_d   = '0;
`ifdef CTRL_FLUSH_EN
                flush_d   = '0;
                state_d   = ST_FLUSH;
`else
                state_d   = ST_IDLE;
`endif
            end

`ifdef CTRL_FLUSH_EN
            // Clock zeros through every datapath register so no shares survive into the next job.
            ST_FLUSH: begin
                out_clear  = 1'b1;
                out_enable = 1'b1;
                out_busy   = 1'b1;
                if (flush_q == LAST_FLUSH) begin
                    flush_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    flush_d = flush_q + 1'b1;
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifndef CTRL_FLUSH_EN
    assign out_clear = 1'b0;
`endif

endmodule

// File: doc/masked_round_ctrl.md
Name: masked_round_ctrl

Overview:
- Sequencer for an iterated masked datapath built from pipeline registers, e.g. a masked cipher round: state register, then PIPE_STAGES gadget register stages, fed back each round.
- Generates load, enable and round-index controls for that datapath.
- Gates each round on fresh randomness from a PRNG through a valid/ready handshake.
- Reports completion with a one-cycle done pulse. Sits between the top-level core FSM/bus interface and the masked round datapath.

Parameters:
- NUM_ROUNDS, 10, number of rounds per operation; must be >= 1.
- PIPE_STAGES, 2, register stages per round (cycles per round without stalls); must be >= 1.
- FLUSH_CYCLES, 2, clear cycles after completion; used only with CTRL_FLUSH_EN; must be >= 1.
- Derived: RW = max(1, $clog2(NUM_ROUNDS)).

Ports:
- in_clock  input  1  clock; all state updates on the rising edge.
- in_reset  input  1  asynchronous, active-low reset.
- in_start  input  1  start request; sampled only in IDLE.
- in_rand_valid  input  1  PRNG has fresh mask randomness.
- out_rand_ready  output  1  controller consumes randomness this cycle when in_rand_valid=1.
- out_busy  output  1  operation in progress.
- out_done  output  1  one-cycle completion pulse.
- out_load  output  1  state register selects external input (instead of feedback).
- out_enable  output  1  advance all datapath registers this cycle.
- out_round  output  RW  current round index.
- out_last  output  1  current round is NUM_ROUNDS-1.
- out_clear  output  1  zero datapath registers (flush).

Behaviour:
- Reset:
  - Asserted (in_reset=0): asynchronously forces IDLE and clears the stage counter s, the round counter and the flush counter.
  - All outputs are 0 while in reset, including mid-operation; no done pulse is produced.
  - Release is synchronous to in_clock; the first active edge after release evaluates IDLE.
- State machine: IDLE, LOAD, ROUND, DONE, plus FLUSH when the macro is defined.
- IDLE:
  - All outputs 0; out_round=0.
  - in_start=1 -> LOAD.
- LOAD (exactly 1 cycle):
  - out_load=1, out_enable=1, out_busy=1, out_round=0.
  - Next state ROUND, with s=0 and round=0.
- ROUND:
  - out_busy=1.
  - out_rand_ready = (s==0).
  - out_enable = (s!=0) OR in_rand_valid.
  - Stall: at s=0 with in_rand_valid=0, out_enable=0 and no counter changes; the datapath holds.
  - On out_enable with s<PIPE_STAGES-1: s increments.
  - On out_enable with s==PIPE_STAGES-1: s=0; if round==NUM_ROUNDS-1 -> DONE, else round increments.
  - PIPE_STAGES=1: every ROUND cycle is s=0 and needs randomness.
- out_round and out_last are driven from registers, never from inputs.
- out_last = (round==NUM_ROUNDS-1) in ROUND only, else 0.
- DONE (1 cycle):
  - out_done=1, out_busy=0, out_enable=0.
  - out_round holds NUM_ROUNDS-1.
  - Next state IDLE (FLUSH with the macro).
- in_start outside IDLE is ignored: not queued, no effect. in_start held high in IDLE restarts on the next edge after DONE/FLUSH completes.
- in_rand_valid outside ROUND s=0 is ignored; out_rand_ready=0 there, so no randomness is consumed.
- Latency:
  - in_start=1 in IDLE at cycle c: LOAD at c+1, ROUND c+2 .. c+1+NUM_ROUNDS*PIPE_STAGES+stalls, DONE the following cycle.
  - Defaults, no stalls: out_done at c+22.
- Exactly NUM_ROUNDS handshakes (out_rand_ready & in_rand_valid) per operation.

Optional Feature:
- Macro: CTRL_FLUSH_EN.
- Defined:
  - DONE -> FLUSH.
  - FLUSH lasts FLUSH_CYCLES cycles with out_clear=1, out_enable=1, out_busy=1, out_round=0, in_start ignored; then IDLE.
  - Purpose: erase shares from datapath registers before reuse, limiting cross-operation leakage.
- Not defined:
  - out_clear is tied to 0 and the FLUSH state and counter do not exist.
  - DONE -> IDLE.

Test Plan:
- Defaults, in_rand_valid=1 constantly, in_start pulse at cycle 0 -> out_load=1 at cycle 1 only; out_enable=1 cycles 1-21; out_round steps 0..9 every 2 cycles; out_last=1 cycles 20-21; out_done=1 at cycle 22 only; exactly 10 handshakes.
- Defaults, in_rand_valid=0 for 3 cycles at round 4 s=0 -> out_enable=0 for those 3 cycles; out_round stays 4; out_done moves to cycle 25.
- in_start pulsed at cycles 5 and 10 during the operation -> ignored; single out_done at 22; IDLE afterwards with out_busy=0.
- in_reset=0 asynchronously mid-round 6 -> all outputs 0 immediately; after release, in_start gives a full fresh operation from round 0.
- NUM_ROUNDS=1, PIPE_STAGES=1, in_rand_valid=1 -> LOAD at 1, ROUND at 2 with out_last=1, out_done at 3; RW=1.
- CTRL_FLUSH_EN defined, defaults -> out_done at 22, out_clear=out_enable=out_busy=1 at cycles 23-24, out_busy=0 at 25; in_start at 23 ignored.
